// File: rtl/gb_oam_pkg.sv
// Shared types and constants for the OAM store / OAM DMA block.
// Object layout in OAM: byte 0 = Y, byte 1 = X, byte 2 = tile, byte 3 = attributes.
package gb_oam_pkg;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] tile;
    logic [7:0] attr;
  } oam_obj_t;

  localparam logic [15:0] OAM_BASE      = 16'hFE00;
  localparam logic [7:0]  ECHO_LO       = 8'hE0;
  localparam logic [7:0]  ECHO_OFS      = 8'h20;
  localparam logic [7:0]  CONFLICT_DATA = 8'hFF;

  typedef enum logic [1:0] {IDLE, START, XFER, DRAIN} oam_xfer_state_t;

  // Pages in the echo region fold back onto work RAM.
  function automatic logic [7:0] dma_page_alias(input logic [7:0] page);
    return (page >= ECHO_LO) ? (page - ECHO_OFS) : page;
  endfunction

endpackage

// File: rtl/gb_oam_xfer_pipe.sv
// Delay line of {valid, index} matching the DMA source read latency.
// LAT=0 is a straight pass-through so the write lands in the issue cycle.
module gb_oam_xfer_pipe #(
  parameter int LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [7:0] in_index,
  output logic       out_valid,
  output logic [7:0] out_index
);

  generate
    if (LAT == 0) begin : g_bypass
      assign out_valid = in_valid;
      assign out_index = in_index;
    end else begin : g_stages
      logic [LAT-1:0] valid_reg;
      logic [7:0]     index_reg [LAT];

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          valid_reg <= '0;
        end else begin
          valid_reg[0] <= in_valid;
          for (int k = 1; k < LAT; k++) valid_reg[k] <= valid_reg[k-1];
        end
        index_reg[0] <= in_index;
        for (int k = 1; k < LAT; k++) index_reg[k] <= index_reg[k-1];
      end

      assign out_valid = valid_reg[LAT-1];
      assign out_index = index_reg[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/gb_oam_xfer.sv
// OAM store with OAM DMA engine: programmable start delay, pipelined source
// reads, restart-while-active, CPU bus-conflict reads and a done pulse.
module gb_oam_xfer
  import gb_oam_pkg::*;
#(
  parameter  int NUM_OBJ   = 40,
  parameter  int SRC_LAT   = 0,
  parameter  int START_DLY = 1,
  localparam int NUM_BYTES = NUM_OBJ * 4,
  localparam int IDX_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dma_start,
  input  logic [7:0]       dma_src_page,
  output logic             dma_rd_en,
  output logic [15:0]      dma_rd_addr,
  input  logic [7:0]       dma_rd_data,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_wdata,
  input  logic             cpu_wren,
  output logic [7:0]       cpu_rdata,
  input  logic [IDX_W-1:0] ppu_index,
  output oam_obj_t         ppu_obj,
  output logic             dma_active,
  output logic             dma_done
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_XFER  = XFER;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

  logic [1:0] state_reg, state_next;
  logic [7:0] page_reg, page_next;
  logic [7:0] i_reg, i_next;
  logic [1:0] dly_reg, dly_next;

  logic       issue_valid, flush;
  logic       wr_valid;
  logic [7:0] wr_index;
  logic [7:0] oam_mem [NUM_BYTES];

  // A trigger is accepted in any state; while active it restarts the run.
  always_comb begin
    state_next = state_reg;
    page_next  = page_reg;
    i_next     = i_reg;
    dly_next   = dly_reg;
    if (dma_start) begin
      page_next  = dma_page_alias(dma_src_page);
      i_next     = 8'h00;
      dly_next   = 2'd0;
      state_next = (START_DLY == 0) ? ST_XFER : ST_START;
    end else begin
      case (state_reg)
        ST_START: begin
          if (32'(dly_reg) == START_DLY - 1) begin
            state_next = ST_XFER;
            dly_next   = 2'd0;
          end else begin
            dly_next = dly_reg + 2'd1;
          end
        end
        ST_XFER: begin
          if (i_reg == LAST_IDX) begin
            state_next = (SRC_LAT > 0) ? ST_DRAIN : ST_IDLE;
            dly_next   = 2'd0;
          end else begin
            i_next = i_reg + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (32'(dly_reg) == SRC_LAT - 1) state_next = ST_IDLE;
          else                             dly_next   = dly_reg + 2'd1;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      page_reg  <= 8'h00;
      i_reg     <= 8'h00;
      dly_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      page_reg  <= page_next;
      i_reg     <= i_next;
      dly_reg   <= dly_next;
    end
  end

  assign issue_valid = (state_reg == ST_XFER);
  assign flush       = dma_start && (state_reg != ST_IDLE);
  assign dma_active  = (state_reg != ST_IDLE);
  assign dma_rd_en   = issue_valid;
  assign dma_rd_addr = issue_valid ? {page_reg, i_reg} : 16'h0000;

  gb_oam_xfer_pipe #(.LAT(SRC_LAT)) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (issue_valid),
    .in_index  (i_reg),
    .out_valid (wr_valid),
    .out_index (wr_index)
  );

  // A restart on the final write cycle aborts the run, so no done pulse then.
  assign dma_done = wr_valid && (wr_index == LAST_IDX) && !dma_start;

  logic [15:0] cpu_ofs;
  logic        cpu_in_win, cpu_we;

  assign cpu_ofs    = cpu_addr - OAM_BASE;
  assign cpu_in_win = (cpu_addr >= OAM_BASE) && (cpu_ofs < 16'(NUM_BYTES));
  assign cpu_we     = cpu_wren && cpu_in_win && (state_reg == ST_IDLE);
  assign cpu_rdata  = (cpu_in_win && !dma_active) ? oam_mem[cpu_ofs[7:0]] : CONFLICT_DATA;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_BYTES; k++) oam_mem[k] <= 8'h00;
    end else if (wr_valid) begin
      oam_mem[wr_index] <= dma_rd_data;
    end else if (cpu_we) begin
      oam_mem[cpu_ofs[7:0]] <= cpu_wdata;
    end
  end

  logic [7:0] obj_base;
  assign obj_base = 8'({ppu_index, 2'b00});

  always_comb begin
    ppu_obj = '0;
    if (32'(ppu_index) < NUM_OBJ) begin
      ppu_obj = {oam_mem[obj_base], oam_mem[obj_base + 8'd1],
                 oam_mem[obj_base + 8'd2], oam_mem[obj_base + 8'd3]};
    end
  end

endmodule

// File: tb/tb_gb_oam_xfer.sv
// Directed bench for gb_oam_xfer: default instance plus a SRC_LAT=2/START_DLY=2 instance.
module tb_gb_oam_xfer;
  import gb_oam_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start1, rd_en1, act1, done1, cpu_wren;
  logic [7:0]  page1, rd_data1, cpu_wdata, cpu_rdata;
  logic [15:0] rd_addr1, cpu_addr;
  logic [5:0]  ppu_idx1;
  oam_obj_t    obj1;

  logic        start2, rd_en2, act2, done2;
  logic [7:0]  page2, rd_data2, cpu_rdata2, src_d1, src_d2;
  logic [15:0] rd_addr2;
  logic [5:0]  ppu_idx2;
  oam_obj_t    obj2;
  logic [15:0] cpu_addr2  = 16'h0000;
  logic [7:0]  cpu_wdata2 = 8'h00;
  logic        cpu_wren2  = 1'b0;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Source memory: byte k of any page is k ^ 5A.
  assign rd_data1 = rd_addr1[7:0] ^ 8'h5A;
  always @(posedge clk) begin
    src_d1 <= rd_addr2[7:0] ^ 8'h5A;
    src_d2 <= src_d1;
  end
  assign rd_data2 = src_d2;

  gb_oam_xfer dut (
    .clk(clk), .reset(reset), .dma_start(start1), .dma_src_page(page1),
    .dma_rd_en(rd_en1), .dma_rd_addr(rd_addr1), .dma_rd_data(rd_data1),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren), .cpu_rdata(cpu_rdata),
    .ppu_index(ppu_idx1), .ppu_obj(obj1), .dma_active(act1), .dma_done(done1)
  );

  gb_oam_xfer #(.SRC_LAT(2), .START_DLY(2)) dut2 (
    .clk(clk), .reset(reset), .dma_start(start2), .dma_src_page(page2),
    .dma_rd_en(rd_en2), .dma_rd_addr(rd_addr2), .dma_rd_data(rd_data2),
    .cpu_addr(cpu_addr2), .cpu_wdata(cpu_wdata2), .cpu_wren(cpu_wren2), .cpu_rdata(cpu_rdata2),
    .ppu_index(ppu_idx2), .ppu_obj(obj2), .dma_active(act2), .dma_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic trigger(input logic [7:0] page);
    start1 = 1'b1;
    page1  = page;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_idle(output int cyc, output int dones);
    cyc = 0;
    dones = 0;
    while (act1 && cyc < 1000) begin
      if (done1) dones++;
      cyc++;
      @(negedge clk);
    end
    check("idle_timeout", 32'(cyc >= 1000), 32'd0);
  endtask

  task automatic wait_addr(input logic [15:0] a);
    int n = 0;
    while (!(rd_en1 && rd_addr1 == a) && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("addr_timeout", 32'(n >= 400), 32'd0);
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    cpu_addr = a;
    #1;
    d = cpu_rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dones, c, first, done_c, nz;
    logic [15:0] exp_addr;
    logic [7:0]  d;

    reset = 1'b1; start1 = 1'b0; page1 = 8'h00; cpu_addr = 16'h0000;
    cpu_wdata = 8'h00; cpu_wren = 1'b0; ppu_idx1 = 6'd0;
    start2 = 1'b0; page2 = 8'h00; ppu_idx2 = 6'd39;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_active", 32'(act1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_rd_en", 32'(rd_en1), 32'd0);
    check("rst_rd_addr", 32'(rd_addr1), 32'h0000);
    check("rst_obj", 32'(obj1), 32'h0);
    check("rst_active2", 32'(act2), 32'd0);
    cpu_read(16'hFE00, d);
    check("rst_oam0", 32'(d), 32'h00);
    @(negedge clk);
    $display("reset state checked");

    // 1: default transfer from page C0
    trigger(8'hC0);
    check("t1_active_rise", 32'(act1), 32'd1);
    check("t1_start_rd_en", 32'(rd_en1), 32'd0);
    exp_addr = 16'hC000; cyc = 0; dones = 0;
    while (act1 && cyc < 400) begin
      if (rd_en1) begin
        check("t1_addr", 32'(rd_addr1), 32'(exp_addr));
        exp_addr++;
      end
      if (done1) dones++;
      cyc++;
      @(negedge clk);
    end
    check("t1_active_cycles", 32'(cyc), 32'd161);
    check("t1_done_count", 32'(dones), 32'd1);
    check("t1_last_addr", 32'(exp_addr), 32'hC0A0);
    for (int k = 0; k < 160; k++) begin
      cpu_read(16'hFE00 + 16'(k), d);
      check("t1_oam", 32'(d), 32'(8'(k) ^ 8'h5A));
    end
    ppu_idx1 = 6'd39; #1;
    check("t1_obj39", 32'(obj1), 32'hC6C7C4C5);
    ppu_idx1 = 6'd40; #1;
    check("t1_obj_out_of_range", 32'(obj1), 32'h0);
    @(negedge clk);
    $display("test1 transfer page C0: cycles=%0d dones=%0d", cyc, dones);

    // 2: SRC_LAT=2, START_DLY=2 instance
    start2 = 1'b1; page2 = 8'hC0;
    @(negedge clk);
    start2 = 1'b0;
    c = 1; first = 0; done_c = 0; dones = 0;
    while (act2 && c < 500) begin
      if (rd_en2 && first == 0) begin
        first = c;
        check("t2_first_addr", 32'(rd_addr2), 32'hC000);
      end
      if (done2) begin
        dones++;
        done_c = c;
        check("t2_tile158_at_done", 32'(obj2.tile), 32'hC4);
        check("t2_attr159_at_done", 32'(obj2.attr), 32'h00);
      end
      c++;
      @(negedge clk);
    end
    check("t2_first_rd_en_cycle", 32'(first), 32'd3);
    check("t2_active_cycles", 32'(c - 1), 32'd164);
    check("t2_done_cycle", 32'(done_c), 32'd164);
    check("t2_done_count", 32'(dones), 32'd1);
    check("t2_attr159_after", 32'(obj2.attr), 32'hC5);
    $display("test2 latency instance: first_rd=%0d active=%0d done_at=%0d", first, c - 1, done_c);

    // 3: echo aliasing and page latching
    trigger(8'hFE);
    page1 = 8'h00;
    check("t3_fe_start_rd_en", 32'(rd_en1), 32'd0);
    @(negedge clk);
    check("t3_fe_first", 32'(rd_addr1), 32'hDE00);
    @(negedge clk);
    check("t3_fe_second", 32'(rd_addr1), 32'hDE01);
    wait_idle(cyc, dones);
    trigger(8'hDF);
    @(negedge clk);
    check("t3_df_first", 32'(rd_addr1), 32'hDF00);
    wait_idle(cyc, dones);
    trigger(8'hE0);
    @(negedge clk);
    check("t3_e0_first", 32'(rd_addr1), 32'hC000);
    wait_idle(cyc, dones);
    $display("test3 aliasing checked");

    // 4: CPU access during and after DMA
    trigger(8'hC0);
    repeat (30) @(negedge clk);
    cpu_addr = 16'hFE10; #1;
    check("t4_read_active", 32'(cpu_rdata), 32'hFF);
    cpu_wdata = 8'h77; cpu_wren = 1'b1;
    @(negedge clk);
    cpu_wren = 1'b0;
    wait_idle(cyc, dones);
    cpu_read(16'hFE10, d);
    check("t4_write_dropped", 32'(d), 32'h4A);
    @(negedge clk);
    cpu_addr = 16'hFE10; cpu_wdata = 8'h77; cpu_wren = 1'b1;
    @(negedge clk);
    cpu_wren = 1'b0;
    cpu_read(16'hFE10, d);
    check("t4_write_idle", 32'(d), 32'h77);
    cpu_read(16'hFEA0, d);
    check("t4_read_fea0", 32'(d), 32'hFF);
    cpu_read(16'hFE9F, d);
    check("t4_read_fe9f", 32'(d), 32'hC5);
    cpu_read(16'hFDFF, d);
    check("t4_read_fdff", 32'(d), 32'hFF);
    @(negedge clk);
    $display("test4 cpu access checked");

    // 5: restart at i=50 with page 80
    trigger(8'hC0);
    wait_addr(16'hC032);
    start1 = 1'b1; page1 = 8'h80;
    @(negedge clk);
    start1 = 1'b0;
    check("t5_active_r1", 32'(act1), 32'd1);
    check("t5_done_r1", 32'(done1), 32'd0);
    check("t5_rd_en_r1", 32'(rd_en1), 32'd0);
    @(negedge clk);
    check("t5_rd_en_r2", 32'(rd_en1), 32'd1);
    check("t5_addr_r2", 32'(rd_addr1), 32'h8000);
    wait_idle(cyc, dones);
    check("t5_active_cycles", 32'(cyc), 32'd160);
    check("t5_done_count", 32'(dones), 32'd1);
    $display("test5 restart: cycles=%0d dones=%0d", cyc, dones);

    // 6: write with trigger, then reset mid-transfer
    cpu_addr = 16'hFE05; cpu_wdata = 8'h33; cpu_wren = 1'b1;
    start1 = 1'b1; page1 = 8'hC0;
    @(negedge clk);
    start1 = 1'b0; cpu_wren = 1'b0;
    ppu_idx1 = 6'd1; #1;
    check("t6_same_cycle_write", 32'(obj1.x), 32'h33);
    wait_addr(16'hC050);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_active_after_reset", 32'(act1), 32'd0);
    check("t6_rd_en_after_reset", 32'(rd_en1), 32'd0);
    nz = 0;
    for (int k = 0; k < 160; k++) begin
      cpu_read(16'hFE00 + 16'(k), d);
      if (d != 8'h00) nz++;
    end
    check("t6_oam_nonzero_bytes", 32'(nz), 32'd0);
    ppu_idx1 = 6'd3; #1;
    check("t6_obj3", 32'(obj1), 32'h0);
    @(negedge clk);
    $display("test6 reset mid-transfer checked");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
